// File: rtl/lfsr_checker.sv
// Locks onto the x -> {x[6:0], x[7]^x[5]} stream and counts mismatches; define LFSR_CHECKER_BITERR_EN to count bit errors.
// Latency: 1 cycle, all outputs registered. Backpressure: none, one sample per cycle.
module lfsr_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam int SW = ERR_W + 4;

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t           state_q, state_n;
  logic [7:0]       exp_q, exp_n;
  logic             exp_ok_q, exp_ok_n;
  logic [MW-1:0]    match_q, match_n;
  logic [LW-1:0]    miss_q, miss_n;
  logic             pulse_n;
  logic [3:0]       add;
  logic [SW-1:0]    sum;
  logic [ERR_W-1:0] count_n;

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5]};
  endfunction

`ifdef LFSR_CHECKER_BITERR_EN
  function automatic logic [3:0] popcnt(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction
`endif

  always_comb begin
    state_n  = state_q;
    exp_n    = exp_q;
    exp_ok_n = exp_ok_q;
    match_n  = match_q;
    miss_n   = miss_q;
    pulse_n  = 1'b0;
    add      = '0;
    if (in_valid) begin
      case (state_q)
        UNLOCKED: begin
          if (in_data == 8'h00) begin
            exp_ok_n = 1'b0;
            match_n  = '0;
          end else if (!exp_ok_q || in_data != exp_q) begin
            exp_n    = lfsr_next(in_data);
            exp_ok_n = 1'b1;
            match_n  = '0;
          end else begin
            exp_n   = lfsr_next(in_data);
            match_n = match_q + 1'b1;
            if (match_n == MW'(LOCK_COUNT)) begin
              state_n = LOCKED;
              miss_n  = '0;
            end
          end
        end
        LOCKED: begin
          // Prediction free-runs so one corrupted word costs exactly one error.
          exp_n = lfsr_next(exp_q);
          if (in_data == 8'h00 || in_data != exp_q) begin
            pulse_n = 1'b1;
`ifdef LFSR_CHECKER_BITERR_EN
            add     = popcnt(in_data ^ exp_q);
`else
            add     = 4'd1;
`endif
            miss_n  = miss_q + 1'b1;
            if (miss_n == LW'(LOSS_COUNT)) begin
              state_n  = UNLOCKED;
              exp_ok_n = 1'b0;
              match_n  = '0;
              miss_n   = '0;
            end
          end else begin
            miss_n = '0;
          end
        end
        default: state_n = UNLOCKED;
      endcase
    end
  end

  always_comb begin
    sum = {4'b0000, err_count} + {{ERR_W{1'b0}}, add};
    if (clear)
      count_n = '0;
    else if (|sum[SW-1:ERR_W])
      count_n = '1;
    else
      count_n = sum[ERR_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= UNLOCKED;
      exp_q     <= '0;
      exp_ok_q  <= 1'b0;
      match_q   <= '0;
      miss_q    <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state_q   <= state_n;
      exp_q     <= exp_n;
      exp_ok_q  <= exp_ok_n;
      match_q   <= match_n;
      miss_q    <= miss_n;
      err_pulse <= pulse_n;
      err_count <= count_n;
    end
  end

  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker built with ERR_W=4 so saturation is reachable.
module tb_lfsr_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_data;
  logic       locked;
  logic       err_pulse;
  logic [3:0] err_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] tb_exp;

`ifdef LFSR_CHECKER_BITERR_EN
  localparam logic [3:0] SINGLE_ERR = 4'd2;
  localparam logic [3:0] LOSS_ERR1  = 4'd4;
  localparam logic [3:0] LOSS_ERR3  = 4'd9;
`else
  localparam logic [3:0] SINGLE_ERR = 4'd1;
  localparam logic [3:0] LOSS_ERR1  = 4'd2;
  localparam logic [3:0] LOSS_ERR3  = 4'd4;
`endif

  lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .ERR_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] nxt(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5]};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic c);
    in_valid = v;
    in_data  = d;
    clear    = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #12;
    check("rst_locked", 16'(locked), 16'd0);
    check("rst_pulse", 16'(err_pulse), 16'd0);
    check("rst_count", 16'(err_count), 16'd0);
    rst_n = 1'b1;

    // Lock on 01..10; exp becomes 0x20
    step(1, 8'h01, 0); step(1, 8'h02, 0); step(1, 8'h04, 0); step(1, 8'h08, 0);
    check("lock_early", 16'(locked), 16'd0);
    step(1, 8'h10, 0);
    check("lock_up", 16'(locked), 16'd1);
    check("lock_count", 16'(err_count), 16'd0);

    // Single corrupted word
    step(1, 8'h23, 0);
    check("single_pulse", 16'(err_pulse), 16'd1);
    check("single_count", 16'(err_count), 16'(SINGLE_ERR));
    step(1, 8'h41, 0);
    check("single_pulse_clr", 16'(err_pulse), 16'd0);
    step(1, 8'h82, 0); step(1, 8'h05, 0);
    check("single_after_count", 16'(err_count), 16'(SINGLE_ERR));
    check("single_locked", 16'(locked), 16'd1);

    // Gaps with garbage data change nothing; exp still 0x0A
    step(0, 8'h00, 0); step(0, 8'h77, 0);
    check("gap_pulse", 16'(err_pulse), 16'd0);
    check("gap_count", 16'(err_count), 16'(SINGLE_ERR));
    step(1, 8'h0A, 0);
    check("gap_resume_pulse", 16'(err_pulse), 16'd0);
    check("gap_resume_locked", 16'(locked), 16'd1);

    // Loss: three zeros against 0x14, 0x28, 0x51
    step(1, 8'h00, 0);
    check("loss1_count", 16'(err_count), 16'(LOSS_ERR1));
    step(1, 8'h00, 0);
    check("loss2_locked", 16'(locked), 16'd1);
    step(1, 8'h00, 0);
    check("loss3_pulse", 16'(err_pulse), 16'd1);
    check("loss3_count", 16'(err_count), 16'(LOSS_ERR3));
    check("loss3_locked", 16'(locked), 16'd0);

    // Relock after 5 clean samples
    step(1, 8'h01, 0); step(1, 8'h02, 0); step(1, 8'h04, 0); step(1, 8'h08, 0);
    check("relock_early", 16'(locked), 16'd0);
    step(1, 8'h10, 0);
    check("relock_up", 16'(locked), 16'd1);
    check("relock_count", 16'(err_count), 16'(LOSS_ERR3));

    // Clear wins over a simultaneous mismatch (exp 0x20)
    step(1, 8'h00, 1);
    check("clr_count", 16'(err_count), 16'd0);
    check("clr_pulse", 16'(err_pulse), 16'd1);
    check("clr_locked", 16'(locked), 16'd1);
    step(1, 8'h41, 0);
    check("clr_next_pulse", 16'(err_pulse), 16'd0);
    tb_exp = 8'h82;

    // 20 single-bit mismatches interleaved with matches: saturates at 15
    for (int i = 0; i < 20; i++) begin
      step(1, tb_exp ^ 8'h01, 0);
      tb_exp = nxt(tb_exp);
      if (i == 0) check("sat_first", 16'(err_count), 16'd1);
      step(1, tb_exp, 0);
      tb_exp = nxt(tb_exp);
    end
    check("sat_count", 16'(err_count), 16'd15);
    check("sat_locked", 16'(locked), 16'd1);

    // Build err_count=5 ending on a mismatch, then async reset mid-cycle
    step(1, tb_exp, 1);
    tb_exp = nxt(tb_exp);
    check("pre_clear", 16'(err_count), 16'd0);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) begin
        step(1, tb_exp, 0);
        tb_exp = nxt(tb_exp);
      end
      step(1, tb_exp ^ 8'h01, 0);
      tb_exp = nxt(tb_exp);
    end
    check("pre_rst_count", 16'(err_count), 16'd5);
    check("pre_rst_pulse", 16'(err_pulse), 16'd1);
    check("pre_rst_locked", 16'(locked), 16'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_locked", 16'(locked), 16'd0);
    check("arst_pulse", 16'(err_pulse), 16'd0);
    check("arst_count", 16'(err_count), 16'd0);
    #2;
    rst_n = 1'b1;
    step(1, tb_exp, 0);
    check("post_rst_locked", 16'(locked), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side companion to the 8-bit LFSR pseudorandom generator. It samples the generator's 8-bit register value stream and locks onto the sequence (feedback `next(x) = {x[6:0], x[7]^x[5]}`, seed never 0). Once locked, it predicts every following word and counts mismatches, so a link or datapath carrying LFSR test patterns can be checked on the FPGA in real time.

## Interface
Parameters:
- `LOCK_COUNT`, default 4: consecutive correct predictions needed to enter LOCKED.
- `LOSS_COUNT`, default 3: consecutive mismatches in LOCKED that force UNLOCKED.
- `ERR_W`, default 16: width of the error counter.

Ports:
- `clk`  in  1: system clock; all logic on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `clear`  in  1: synchronous clear of `err_count` only.
- `in_valid`  in  1: `in_data` carries a sample this cycle.
- `in_data`  in  8: observed LFSR word.
- `locked`  out  1: checker is synchronized.
- `err_pulse`  out  1: one-cycle strobe for a mismatched sample while locked.
- `err_count`  out  ERR_W: saturating error count.

## Operation
- State: `state` (UNLOCKED/LOCKED), `exp[7:0]`, `exp_ok`, `match_cnt`, `miss_cnt`.
- Reset (`rst_n`=0) forces the following immediately:
  - `state`=UNLOCKED, `exp_ok`=0, both counters 0.
  - `locked`=0, `err_pulse`=0, `err_count`=0.
- Cycles with `in_valid`=0 change nothing, and `err_pulse` is 0.
- UNLOCKED, valid sample `d`:
  - `d`==0: `exp_ok`=0, `match_cnt`=0. A zero word is never a seed.
  - `exp_ok`=0 and `d`≠0: `exp`=next(`d`), `exp_ok`=1, `match_cnt`=0.
  - `exp_ok`=1 and `d`==`exp`: `match_cnt`+1, `exp`=next(`d`). When `match_cnt` reaches `LOCK_COUNT`, go to LOCKED with `miss_cnt`=0.
  - `exp_ok`=1 and `d`≠`exp`: reseed. `exp`=next(`d`), `match_cnt`=0.
  - No errors are counted while UNLOCKED.
- LOCKED, valid sample `d`:
  - `exp` always advances from the prediction: `exp`=next(`exp`). The received word is not used, so a single corrupted word costs exactly one error.
  - `d`==`exp` (0 is always a mismatch): `miss_cnt`=0.
  - Mismatch: `err_pulse`=1, `err_count` incremented, `miss_cnt`+1.
  - `miss_cnt` reaching `LOSS_COUNT`: go to UNLOCKED with `exp_ok`=0, `match_cnt`=0. The next nonzero sample reseeds.
- `err_count` saturates at all-ones and never wraps.
- `clear`=1 sets `err_count`=0 and takes priority over a simultaneous increment (result 0). It does not affect lock state or `err_pulse`.

## Timing
- All outputs are registered.
- Sample accepted at edge k: `err_pulse`, the `err_count` update and the `locked` change are visible after edge k, i.e. exactly 1 cycle latency.
- Minimum lock time from reset: `LOCK_COUNT`+1 valid samples.
- Back-to-back valid samples are accepted every cycle. No backpressure.
- Deasserting `rst_n` mid-operation discards lock. Outputs go to their reset values asynchronously, not at the next edge.

## Configuration
- `LFSR_CHECKER_BITERR_EN` defined:
  - A mismatched sample adds popcount(`d` ^ `exp`) to `err_count` (1–8), saturating.
  - A received 0 against expected `e` adds popcount(`e`).
- `LFSR_CHECKER_BITERR_EN` undefined:
  - Each mismatched sample adds exactly 1.
- Lock/loss logic and `err_pulse` are identical in both builds.

## Test plan
- Lock: after reset, send valid 0x01,0x02,0x04,0x08,0x10 on consecutive cycles. `locked` rises the cycle after 0x10 is sampled, and `err_count`=0.
- Single error: while locked and expecting 0x20, send 0x23, then 0x41,0x82,0x05.
  - One `err_pulse`; `err_count`=1 (2 with `LFSR_CHECKER_BITERR_EN`).
  - No further errors; `locked` stays 1.
- Loss: while locked, send 3 zero words. `err_count`+3, then `locked`=0 one cycle after the 3rd. Resend a clean sequence and lock is regained after 5 samples.
- Gaps and saturation: with `ERR_W`=4, insert `in_valid`=0 gaps between samples (no state change), then force 20 mismatches. `err_count` holds at 15.
- Clear priority: assert `clear` in the same cycle as a mismatch. `err_count`=0 afterwards, `err_pulse`=1, and `locked` is unchanged.
- Async reset: drop `rst_n` between clock edges while locked with `err_count`=5. `locked`, `err_pulse` and `err_count` are 0 before the next edge.
